// File: rtl/f_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : f_fetch_unit_pkg
//  Purpose  : Shared constants, fetch-state encoding and F/D register layout
//             for the F-stage fetch engine.
//  Revision : 1.0  initial release
// ============================================================================
package f_fetch_unit_pkg;

    // Default fetch window: instruction memory occupies 0x3000..0x6FFF
    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] c_IM_LIMIT = 32'h0000_6FFF;

    // Fetch engine states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // nothing outstanding, buffer empty
        S_WAIT = 2'd1,   // one read outstanding
        S_HELD = 2'd2    // returned word parked while pipeline stalls
    } fetch_state_e;

    // F/D pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        adel;
    } fd_reg_t;

    // Sequential PC, wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/f_adel_check.sv
`default_nettype none
// ============================================================================
//  Module   : f_adel_check
//  Purpose  : Combinational word-alignment and address-window checker.
//             Flags an address that is misaligned or outside [BASE, LIMIT].
//  Revision : 1.0  initial release
// ============================================================================
module f_adel_check #(
    parameter logic [31:0] BASE  = 32'h0000_3000,
    parameter logic [31:0] LIMIT = 32'h0000_6FFF
) (
    input  logic [31:0] addr_i,
    output logic        bad_o
);

    // Unsigned compares against the legal window plus word alignment
    always_comb begin
        bad_o = (addr_i[1:0] != 2'b00) || (addr_i < BASE) || (addr_i > LIMIT);
    end

endmodule
`default_nettype wire

// File: rtl/f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : f_fetch_unit
//  Purpose  : F-stage fetch engine. Holds the PC, issues single-outstanding
//             instruction reads, parks a returned word across stalls and
//             writes the F/D pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] IM_BASE  = c_IM_BASE,
    parameter logic [31:0] IM_LIMIT = c_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc_in,
    output logic [31:0] pc_f,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_rvalid,
    output logic        f_ready,
    output logic [31:0] instr_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        adel_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    fd_reg_t      fd_q, fd_d;

    logic         pc_bad;
    logic         npc_bad;
    logic [31:0]  fetch_word;
    logic         fetch_adel;
    logic         xfer;

    // Address error check on the current PC
    f_adel_check #(
        .BASE  (IM_BASE),
        .LIMIT (IM_LIMIT)
    ) u_adel_pc (
        .addr_i (pc_q),
        .bad_o  (pc_bad)
    );

    // Address error check on the incoming next PC, for back-to-back issue
    f_adel_check #(
        .BASE  (IM_BASE),
        .LIMIT (IM_LIMIT)
    ) u_adel_npc (
        .addr_i (npc_in),
        .bad_o  (npc_bad)
    );

    // Next-state, request and F/D write logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        fd_d       = fd_q;
        im_req     = 1'b0;
        im_addr    = pc_q;
        f_ready    = 1'b0;
        fetch_word = 32'd0;
        fetch_adel = 1'b0;

        case (state_q)
            S_REQ: begin
                if (pc_bad) begin
                    // Bad address never reaches memory; deliver a nop with the flag
                    f_ready    = 1'b1;
                    fetch_adel = 1'b1;
                end else begin
                    im_req  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    f_ready    = 1'b1;
                    fetch_word = im_rdata;
                    if (stall) begin
                        buf_d   = im_rdata;
                        state_d = S_HELD;
                    end
                end
            end
            S_HELD: begin
                f_ready    = 1'b1;
                fetch_word = buf_q;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        xfer = f_ready && !stall;

        // Transfer: write F/D, take the next PC and, if legal, issue it at once
        if (xfer) begin
            fd_d.instr = fetch_word;
            fd_d.pc4   = pc_plus4(pc_q);
            fd_d.valid = 1'b1;
            fd_d.adel  = fetch_adel;
            pc_d       = npc_in;
            if (!npc_bad) begin
                im_req  = 1'b1;
                im_addr = npc_in;
                state_d = S_WAIT;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // State, PC, buffer and F/D registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'd0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            fd_q    <= fd_d;
        end
    end

    assign pc_f    = pc_q;
    assign instr_d = fd_q.instr;
    assign pc4_d   = fd_q.pc4;
    assign valid_d = fd_q.valid;
    assign adel_d  = fd_q.adel;

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f_fetch_unit
//  Purpose  : Self-checking bench for f_fetch_unit with an instruction-memory
//             responder of configurable latency and an F/D scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_f_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] npc_in = 32'd0;
    logic [31:0] im_rdata = 32'd0;
    logic        im_rvalid = 1'b0;
    logic [31:0] pc_f;
    logic        im_req;
    logic [31:0] im_addr;
    logic        f_ready;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        adel_d;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];
    logic [66:0] model_fd = '0;
    logic        mon_en = 1'b0;
    logic        rst_seen = 1'b1;
    logic        xfer_seen = 1'b0;

    int          lat_cfg = 1;
    int          im_cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    logic [31:0] rd_from[3];
    logic [31:0] rd_to[3];

    f_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_in    (npc_in),
        .pc_f      (pc_f),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .im_rvalid (im_rvalid),
        .f_ready   (f_ready),
        .instr_d   (instr_d),
        .pc4_d     (pc4_d),
        .valid_d   (valid_d),
        .adel_d    (adel_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory content: opcode-ish tag plus the low address bits
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {16'h2400, a[15:0]};
    endfunction

    // Bench-side next-PC logic: sequential unless a redirect entry matches
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        for (int i = 0; i < 3; i++)
            if (rd_from[i] == pc) return rd_to[i];
        return pc + 32'd4;
    endfunction

    // Instruction memory responder, latency captured at request time
    always @(posedge clk) begin
        im_rvalid <= 1'b0;
        if (reset) begin
            im_cnt = 0;
        end else begin
            if (im_cnt > 0) begin
                im_cnt = im_cnt - 1;
                if (im_cnt == 0) begin
                    im_rvalid <= 1'b1;
                    im_rdata  <= im_word(pend_addr);
                end
            end
            if (im_req) begin
                chk("one_outstanding", 128'(im_cnt != 0), 128'(0));
                pend_addr = im_addr;
                if (lat_cfg == 1) begin
                    im_rvalid <= 1'b1;
                    im_rdata  <= im_word(im_addr);
                end else begin
                    im_cnt = lat_cfg - 1;
                end
            end
        end
    end

    // Scoreboard monitor: pops an expectation on each observed transfer and
    // checks that the F/D register otherwise holds
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                model_fd = '0;
            end else if (xfer_seen) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    model_fd = {e.instr, e.pc4, 1'b1, e.adel};
                end
            end
            chk("fd_reg", 128'({instr_d, pc4_d, valid_d, adel_d}), 128'(model_fd));
            rst_seen  = reset;
            xfer_seen = f_ready && !stall && !reset;
        end
    end

    task automatic tick(input logic st, input logic rs);
        @(posedge clk);
        #1;
        stall  = st;
        reset  = rs;
        npc_in = next_pc(pc_f);
        #3;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4, input logic adel);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        e.adel  = adel;
        sb.push_back(e);
    endtask

    task automatic drain_chk(input string name);
        chk(name, 128'(sb.size()), 128'(0));
    endtask

    // Reset sequence; returns positioned in the first cycle after release
    task automatic start(input int lat);
        lat_cfg = lat;
        for (int i = 0; i < 3; i++) begin
            rd_from[i] = 32'hFFFF_FFFF;
            rd_to[i]   = 32'd0;
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s1_addr[4];
        for (int i = 0; i < 3; i++) begin
            rd_from[i] = 32'hFFFF_FFFF;
            rd_to[i]   = 32'd0;
        end

        // ---------------- latency 1 streaming with a branch redirect
        start(1);
        rd_from[0] = 32'h0000_3008; rd_to[0] = 32'h0000_3040;
        push(32'h2400_3000, 32'h0000_3004, 1'b0);
        push(32'h2400_3004, 32'h0000_3008, 1'b0);
        push(32'h2400_3008, 32'h0000_300C, 1'b0);
        push(32'h2400_3040, 32'h0000_3044, 1'b0);
        chk("rst_pc_f",    128'(pc_f),    128'(32'h0000_3000));
        chk("rst_valid_d", 128'(valid_d), 128'(0));
        chk("rst_f_ready", 128'(f_ready), 128'(0));
        chk("s1_req0",     128'(im_req),  128'(1));
        chk("s1_addr0",    128'(im_addr), 128'(32'h0000_3000));
        s1_addr[0] = 32'h0000_3004; s1_addr[1] = 32'h0000_3008;
        s1_addr[2] = 32'h0000_3040; s1_addr[3] = 32'h0000_3044;
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 1'b0);
            chk("s1_req",  128'(im_req),  128'(1));
            chk("s1_addr", 128'(im_addr), 128'(s1_addr[c-1]));
            if (c >= 2) chk("s1_valid_d", 128'(valid_d), 128'(1));
        end
        chk("s1_branch_pc4", 128'(pc4_d), 128'(32'h0000_300C));
        tick(1'b1, 1'b0);
        chk("s1_stall_noreq", 128'(im_req), 128'(0));
        tick(1'b1, 1'b0);
        chk("s1_stall_noreq", 128'(im_req), 128'(0));
        drain_chk("s1_drain");

        // ---------------- latency 3, gaps between fetches
        start(3);
        push(32'h2400_3000, 32'h0000_3004, 1'b0);
        push(32'h2400_3004, 32'h0000_3008, 1'b0);
        chk("s2_req0", 128'(im_req), 128'(1));
        for (int c = 1; c <= 8; c++) begin
            tick(1'b0, 1'b0);
            chk("s2_req",     128'(im_req),  128'((c % 3) == 0));
            chk("s2_f_ready", 128'(f_ready), 128'((c % 3) == 0));
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        drain_chk("s2_drain");

        // ---------------- response arrives during a 4-cycle stall
        start(2);
        push(32'h2400_3000, 32'h0000_3004, 1'b0);
        push(32'h2400_3004, 32'h0000_3008, 1'b0);
        chk("s3_req0", 128'(im_req), 128'(1));
        tick(1'b0, 1'b0);
        chk("s3_gap_ready", 128'(f_ready), 128'(0));
        for (int c = 2; c <= 5; c++) begin
            tick(1'b1, 1'b0);
            chk("s3_held_noreq", 128'(im_req), 128'(0));
            if (c >= 3) chk("s3_held_ready", 128'(f_ready), 128'(1));
        end
        tick(1'b0, 1'b0);
        chk("s3_release_req",  128'(im_req),  128'(1));
        chk("s3_release_addr", 128'(im_addr), 128'(32'h0000_3004));
        tick(1'b0, 1'b0);
        chk("s3_buf_instr", 128'(instr_d), 128'(32'h2400_3000));
        chk("s3_wait_ready", 128'(f_ready), 128'(0));
        tick(1'b0, 1'b0);
        chk("s3_next_req",  128'(im_req),  128'(1));
        chk("s3_next_addr", 128'(im_addr), 128'(32'h0000_3008));
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        drain_chk("s3_drain");

        // ---------------- misaligned / out-of-range next PC, then reset in S_WAIT
        start(1);
        rd_from[0] = 32'h0000_3004; rd_to[0] = 32'h0000_3002;
        rd_from[1] = 32'h0000_3002; rd_to[1] = 32'h0000_7000;
        rd_from[2] = 32'h0000_7000; rd_to[2] = 32'h0000_3010;
        push(32'h2400_3000, 32'h0000_3004, 1'b0);
        push(32'h2400_3004, 32'h0000_3008, 1'b0);
        push(32'h0000_0000, 32'h0000_3006, 1'b1);
        push(32'h0000_0000, 32'h0000_7004, 1'b1);
        push(32'h2400_3010, 32'h0000_3014, 1'b0);
        tick(1'b0, 1'b0);
        chk("s4_addr1", 128'(im_addr), 128'(32'h0000_3004));
        tick(1'b0, 1'b0);
        chk("s4_badnpc_noreq", 128'(im_req),  128'(0));
        chk("s4_ready2",       128'(f_ready), 128'(1));
        tick(1'b0, 1'b0);
        chk("s4_pc_bad",      128'(pc_f),    128'(32'h0000_3002));
        chk("s4_misal_noreq", 128'(im_req),  128'(0));
        chk("s4_misal_ready", 128'(f_ready), 128'(1));
        tick(1'b0, 1'b0);
        chk("s4_adel_fd", 128'({instr_d, pc4_d, valid_d, adel_d}),
            128'({32'h0000_0000, 32'h0000_3006, 1'b1, 1'b1}));
        chk("s4_range_ready", 128'(f_ready), 128'(1));
        chk("s4_recover_req",  128'(im_req),  128'(1));
        chk("s4_recover_addr", 128'(im_addr), 128'(32'h0000_3010));
        tick(1'b0, 1'b0);
        lat_cfg = 4;
        chk("s4_req5",  128'(im_req),  128'(1));
        chk("s4_addr5", 128'(im_addr), 128'(32'h0000_3014));
        tick(1'b0, 1'b1);
        chk("s4_wait_ready", 128'(f_ready), 128'(0));
        tick(1'b0, 1'b0);
        chk("s5_pc_f",    128'(pc_f),    128'(32'h0000_3000));
        chk("s5_valid_d", 128'(valid_d), 128'(0));
        chk("s5_req",     128'(im_req),  128'(1));
        chk("s5_addr",    128'(im_addr), 128'(32'h0000_3000));
        drain_chk("s4_drain");
        push(32'h2400_3000, 32'h0000_3004, 1'b0);
        for (int c = 8; c <= 10; c++) begin
            tick(1'b0, 1'b0);
            chk("s5_gap_ready", 128'(f_ready), 128'(0));
        end
        tick(1'b0, 1'b0);
        chk("s5_ready",     128'(f_ready), 128'(1));
        chk("s5_next_addr", 128'(im_addr), 128'(32'h0000_3004));
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        @(negedge clk);
        #1;
        drain_chk("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
